// File: rtl/inst_mem_pipe.sv
// -----------------------------------------------------------------------------
// inst_mem_pipe
//
// Registered instruction memory for the fetch stage. A request is accepted on
// req_valid && req_ready. The addressed word appears in a one-entry response
// register in the following cycle, and it stays stable while the consumer
// back-pressures. A byte-enabled write port loads programs at runtime and is
// never stalled. fetch_cnt counts accepted requests and wraps.
//
// Optional feature (macro INST_MEM_ERR_EN):
//   If defined, a request faults when the byte address is misaligned or its
//   word index is >= DEPTH. A faulting request returns rsp_err=1 with a NOP
//   word, and out-of-range writes are dropped.
//   If undefined, rsp_err is 0, the low address bits are ignored, and word
//   indices wrap modulo DEPTH.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready/req_adr fetch request channel (byte address)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_adr/rsp_err    fetched word, its byte address, fault flag
//   wr_en/wr_be/wr_adr/wr_data  byte-enabled write port
//   fetch_cnt                   number of accepted fetches (wraps)
// -----------------------------------------------------------------------------
module inst_mem_pipe #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_adr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_data,
    output logic [ADDR_W-1:0]   rsp_adr,
    output logic                rsp_err,
    input  logic                wr_en,
    input  logic [XLEN/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]   wr_adr,
    input  logic [XLEN-1:0]     wr_data,
    output logic [CNT_W-1:0]    fetch_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = XLEN / 8;
    localparam logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e          state_q, state_d;
    logic                accept;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                rd_fault;
    logic                wr_ok;
    logic                unused_adr_bits;

    logic [XLEN-1:0]     mem [DEPTH];

    assign rd_idx = req_adr[IDX_W+1:2];
    assign wr_idx = wr_adr[IDX_W+1:2];

`ifdef INST_MEM_ERR_EN
    // With DEPTH a power of two, (adr >> 2) >= DEPTH is the same as any
    // address bit above the index field being set.
    assign rd_fault = (req_adr[1:0] != 2'b00) || (req_adr[ADDR_W-1:IDX_W+2] != '0);
    assign wr_ok    = (wr_adr[ADDR_W-1:IDX_W+2] == '0);
    assign unused_adr_bits = ^wr_adr[1:0];
`else
    assign rd_fault = 1'b0;
    assign wr_ok    = 1'b1;
    assign unused_adr_bits = ^{req_adr[1:0], req_adr[ADDR_W-1:IDX_W+2],
                               wr_adr[1:0], wr_adr[ADDR_W-1:IDX_W+2]};
`endif

    // ------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register in this block samples pre-edge values. The
            // read-before-write collision rule depends on this too.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case can infer a latch.
        state_d   = state_q;
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        case (state_q)
            EMPTY: begin
                if (req_valid) state_d = FULL;
            end
            FULL: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                // Consumer drains and nothing new arrives: go empty.
                // A simultaneous accept reloads the register and stays FULL.
                if (rsp_ready && !req_valid) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign accept = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Storage and write port
    // ------------------------------------------------------------------
    // NOTE: the memory array is deliberately left out of reset. Program
    // contents must survive rst_n, and a reset here would stop the array
    // from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register and fetch counter
    // ------------------------------------------------------------------
    // The register loads only on accept. Under back-pressure req_ready is 0,
    // so the held response cannot be disturbed, including by writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_adr   <= '0;
            rsp_err   <= 1'b0;
            fetch_cnt <= '0;
        end else if (accept) begin
            rsp_data  <= rd_fault ? NOP_WORD : mem[rd_idx];
            rsp_adr   <= req_adr;
            rsp_err   <= rd_fault;
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_pipe
//
// Scoreboard bench for inst_mem_pipe. The fetch task pushes the hand-computed
// expected response at acceptance. A negedge monitor pops and compares each
// response as the consumer takes it. CNT_W is reduced to 4 so that the
// counter wrap falls inside a short run.
// -----------------------------------------------------------------------------
module tb_inst_mem_pipe;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_adr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [XLEN-1:0]   rsp_data;
    logic [ADDR_W-1:0] rsp_adr;
    logic              rsp_err;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_be = '0;
    logic [ADDR_W-1:0] wr_adr = '0;
    logic [XLEN-1:0]   wr_data = '0;
    logic [CNT_W-1:0]  fetch_cnt;

    typedef struct {
        logic [31:0] data;
        logic [31:0] adr;
        logic        err;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [3:0] exp_cnt = '0;
    int         n_checks = 0;
    int         n_fail   = 0;

    inst_mem_pipe #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_adr(rsp_adr), .rsp_err(rsp_err),
        .wr_en(wr_en), .wr_be(wr_be), .wr_adr(wr_adr), .wr_data(wr_data),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a response is consumed at the coming edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected response", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_adr",  64'(rsp_adr),  64'(e.adr));
                check("rsp_err",  64'(rsp_err),  64'(e.err));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_adr = adr; wr_data = d; wr_be = be;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Issue one fetch. When track is set, the expected response goes into
    // the scoreboard.
    task automatic fetch(input logic [31:0] adr, input logic [31:0] d,
                         input logic e, input bit track);
        int n = 0;
        req_valid = 1'b1;
        req_adr   = adr;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check("req_ready timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
        end else begin
            if (track) exp_q.push_back('{data: d, adr: adr, err: e});
            exp_cnt++;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("rsp_valid after accept", 64'(rsp_valid), 64'd1);
            check("fetch_cnt", 64'(fetch_cnt), 64'(exp_cnt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset rsp_data",  64'(rsp_data),  64'd0);
        check("reset fetch_cnt", 64'(fetch_cnt), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);
        check("post-reset req_ready", 64'(req_ready), 64'd1);

        // Load program, then back-to-back fetches
        write(32'h0, 32'h0000_2083, 4'hF);
        write(32'h4, 32'h0010_2103, 4'hF);
        write(32'h8, 32'h0011_01B3, 4'hF);
        fetch(32'h0, 32'h0000_2083, 1'b0, 1'b1);
        fetch(32'h4, 32'h0010_2103, 1'b0, 1'b1);
        fetch(32'h8, 32'h0011_01B3, 1'b0, 1'b1);
        check("fetch_cnt after 3", 64'(fetch_cnt), 64'd3);
        idle(2);

        // Back-pressure with a write to the held word
        rsp_ready = 1'b0;
        fetch(32'h4, 32'h0010_2103, 1'b0, 1'b1);
        wr_en = 1'b1; wr_adr = 32'h4; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("stall rsp_data",  64'(rsp_data),  64'h0010_2103);
            check("stall req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            wr_en = 1'b0;
        end
        rsp_ready = 1'b1;
        idle(1);
        fetch(32'h4, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Partial byte write
        write(32'hC, 32'h1234_5678, 4'hF);
        write(32'hC, 32'h0000_AB00, 4'b0010);
        fetch(32'hC, 32'h1234_AB78, 1'b0, 1'b1);

        // Same-cycle read/write collision reads old data
        wr_en = 1'b1; wr_adr = 32'h8; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        fetch(32'h8, 32'h0011_01B3, 1'b0, 1'b1);
        wr_en = 1'b0;
        fetch(32'h8, 32'hDEAD_BEEF, 1'b0, 1'b1);

`ifdef INST_MEM_ERR_EN
        fetch(32'h2,   32'h0000_0013, 1'b1, 1'b1);
        fetch(32'h100, 32'h0000_0013, 1'b1, 1'b1);
        write(32'h100, 32'h0BAD_0BAD, 4'hF);
        fetch(32'h0,   32'h0000_2083, 1'b0, 1'b1);
`else
        fetch(32'h100, 32'h0000_2083, 1'b0, 1'b1);
        fetch(32'h2,   32'h0000_2083, 1'b0, 1'b1);
`endif

        // Run the 4-bit counter through its wrap
        for (int i = 0; i < 8; i++) begin
            fetch(32'h0, 32'h0000_2083, 1'b0, 1'b1);
        end
        idle(2);

        // Reset while a stalled response is held
        rsp_ready = 1'b0;
        fetch(32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid reset rsp_data",  64'(rsp_data),  64'd0);
        check("mid reset rsp_adr",   64'(rsp_adr),   64'd0);
        check("mid reset rsp_err",   64'(rsp_err),   64'd0);
        check("mid reset fetch_cnt", 64'(fetch_cnt), 64'd0);
        check("mid reset req_ready", 64'(req_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(1);
        fetch(32'h0, 32'h0000_2083, 1'b0, 1'b1);

        idle(3);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
